// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode/funct constants, ALU op codes and the decoded-packet type
// shared by the decode stage and its combinational decoder.
package rv32_pkg;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;
   localparam logic [4:0] ALU_ILL  = 5'b00000;
   localparam logic [4:0] ALU_JAL  = 5'b10000;
   localparam logic [4:0] ALU_BEQ  = 5'b10001;
   localparam logic [4:0] ALU_LW   = 5'b10100;
   localparam logic [4:0] ALU_SW   = 5'b10101;
   localparam logic [4:0] ALU_ADDI = 5'b01100;
   localparam logic [4:0] ALU_ADD  = 5'b01101;
   localparam logic [4:0] ALU_SUB  = 5'b01110;
   localparam logic [4:0] ALU_SLL  = 5'b01000;
   localparam logic [4:0] ALU_SRL  = 5'b01001;
   localparam logic [4:0] ALU_XOR  = 5'b00110;
   localparam logic [4:0] ALU_OR   = 5'b00101;
   localparam logic [4:0] ALU_AND  = 5'b00100;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        use_imm;
      logic [31:0] imm;
      logic        illegal;
   } dec_t;

   // R-type op lookup; ALU_ILL marks an unsupported funct3/funct7 pair
   function automatic logic [4:0] alu_rop(input logic [2:0] f3, input logic [6:0] f7);
      if (f7 == F7_SUB) return (f3 == F3_ADD) ? ALU_SUB : ALU_ILL;
      if (f7 != F7_BASE) return ALU_ILL;
      case (f3)
         F3_ADD:  return ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_XOR:  return ALU_XOR;
         F3_SRL:  return ALU_SRL;
         F3_OR:   return ALU_OR;
         F3_AND:  return ALU_AND;
         default: return ALU_ILL;
      endcase
   endfunction
endpackage

// File: rtl/rv32_decode_comb.sv
// rv32_decode_comb: purely combinational RV32I subset decoder, instruction word to
// ALU op, register fields, write enable, immediate and illegal flag.
module rv32_decode_comb
   import rv32_pkg::*;
(
   input  logic [31:0] i_instr,
   output dec_t        o_dec
);
   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [4:0]  w_rop;
   logic        w_jal, w_beq, w_lw, w_sw, w_addi, w_r;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;

   assign w_opc = i_instr[6:0];
   assign w_f3  = i_instr[14:12];
   assign w_f7  = i_instr[31:25];
   assign w_rop = alu_rop(w_f3, w_f7);
   assign w_jal  = w_opc == OPC_JAL;
   assign w_beq  = w_opc == OPC_BRANCH && w_f3 == F3_BEQ;
   assign w_lw   = w_opc == OPC_LOAD   && w_f3 == F3_W;
   assign w_sw   = w_opc == OPC_STORE  && w_f3 == F3_W;
   assign w_addi = w_opc == OPC_OPIMM  && w_f3 == F3_ADD;
   assign w_r    = w_opc == OPC_RTYPE  && w_rop != ALU_ILL;
   assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      o_dec.op      = w_jal ? ALU_JAL : w_beq ? ALU_BEQ : w_lw ? ALU_LW : w_sw ? ALU_SW :
                      w_addi ? ALU_ADDI : w_r ? w_rop : ALU_ILL;
      o_dec.illegal = !(w_jal | w_beq | w_lw | w_sw | w_addi | w_r);
      o_dec.rs1     = w_jal ? 5'd0 : i_instr[19:15];
      o_dec.rs2     = (w_jal | w_lw | w_addi) ? 5'd0 : i_instr[24:20];
      o_dec.rd      = i_instr[11:7];
      o_dec.rd_we   = (w_jal | w_lw | w_addi | w_r) && |i_instr[11:7];
      o_dec.use_imm = w_lw | w_sw | w_addi;
      o_dec.imm     = (w_lw | w_addi) ? w_imm_i : w_sw ? w_imm_s : w_beq ? w_imm_b :
                      w_jal ? w_imm_j : 32'd0;
   end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decode stage between fetch and execute; registered main entry
// drives the outputs, a skid entry absorbs one packet so in_ready is purely registered.
module id_decode_stage
   import rv32_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SKID_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_op,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic            out_rd_we,
   output logic            out_use_imm,
   output logic [31:0]     out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);
   if (SKID_DEPTH != 2) begin : g_depth_chk
      $error("id_decode_stage supports only SKID_DEPTH = 2");
   end

   dec_t            w_dec, r_m, r_s;
   logic [XLEN-1:0] r_m_pc, r_s_pc;
   logic            r_m_valid, r_s_valid;
   logic            w_acc, w_m_free;

   rv32_decode_comb u_dec (.i_instr(in_instr), .o_dec(w_dec));

   assign w_acc    = in_valid & !r_s_valid;
   assign w_m_free = !r_m_valid | out_ready;

   // skid is only ever occupied while main is stalled, so draining main always refills from skid first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m       <= '0;
         r_s       <= '0;
         r_m_pc    <= '0;
         r_s_pc    <= '0;
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (flush) begin
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (w_m_free) begin
         if (r_s_valid) begin
            r_m       <= r_s;
            r_m_pc    <= r_s_pc;
            r_m_valid <= 1'b1;
            r_s_valid <= 1'b0;
         end else begin
            r_m_valid <= w_acc;
            if (w_acc) begin
               r_m    <= w_dec;
               r_m_pc <= in_pc;
            end
         end
      end else if (w_acc) begin
         r_s       <= w_dec;
         r_s_pc    <= in_pc;
         r_s_valid <= 1'b1;
      end
   end

   assign in_ready    = !r_s_valid;
   assign out_valid   = r_m_valid;
   assign out_op      = r_m.op;
   assign out_rs1     = r_m.rs1;
   assign out_rs2     = r_m.rs2;
   assign out_rd      = r_m.rd;
   assign out_rd_we   = r_m.rd_we;
   assign out_use_imm = r_m.use_imm;
   assign out_imm     = r_m.imm;
   assign out_pc      = r_m_pc;
   assign out_illegal = r_m.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed vectors for the decode stage with hand-computed
// expected decode fields, handshake latency, backpressure, flush and reset behaviour.
module tb_id_decode_stage;
   logic        clk = 0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_imm, out_pc;
   logic [4:0]  out_op, out_rs1, out_rs2, out_rd;
   logic        out_rd_we, out_use_imm, out_illegal;
   int          n_chk = 0, n_pass = 0;

   id_decode_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_use_imm(out_use_imm),
      .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_dec(input string tag, input logic [4:0] op, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                             input logic use_imm, input logic [31:0] imm, input logic ill,
                             input logic [31:0] pc);
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".op"}, out_op, op);
      check({tag, ".rs1"}, out_rs1, rs1);
      check({tag, ".rs2"}, out_rs2, rs2);
      check({tag, ".rd"}, out_rd, rd);
      check({tag, ".rd_we"}, out_rd_we, we);
      check({tag, ".use_imm"}, out_use_imm, use_imm);
      check({tag, ".imm"}, out_imm, imm);
      check({tag, ".illegal"}, out_illegal, ill);
      check({tag, ".pc"}, out_pc, pc);
   endtask

   // one accepted beat with out_ready high; the packet must be on the outputs one cycle later
   task automatic send(input logic [31:0] instr, input logic [31:0] pc);
      in_instr  = instr;
      in_pc     = pc;
      in_valid  = 1;
      out_ready = 1;
      tick();
      in_valid = 0;
   endtask

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
      #12;
      check("rst.out_valid", out_valid, 0);
      check("rst.in_ready", in_ready, 1);
      check("rst.op", out_op, 0);
      check("rst.imm", out_imm, 0);
      check("rst.pc", out_pc, 0);
      rst_n = 1;
      tick();

      send(32'h00500093, 32'h1000); expect_dec("addi", 5'b01100, 0, 0, 1, 1, 1, 32'h5, 0, 32'h1000);
      send(32'h002081B3, 32'h1004); expect_dec("add", 5'b01101, 1, 2, 3, 1, 0, 32'h0, 0, 32'h1004);
      send(32'h402081B3, 32'h1008); expect_dec("sub", 5'b01110, 1, 2, 3, 1, 0, 32'h0, 0, 32'h1008);
      send(32'hFFC12283, 32'h100C); expect_dec("lw", 5'b10100, 2, 0, 5, 1, 1, 32'hFFFFFFFC, 0, 32'h100C);
      send(32'h00512423, 32'h1010); expect_dec("sw", 5'b10101, 2, 5, 8, 0, 1, 32'h8, 0, 32'h1010);
      send(32'h00208863, 32'h1014); expect_dec("beq", 5'b10001, 1, 2, 16, 0, 0, 32'h10, 0, 32'h1014);
      send(32'h001000EF, 32'h1018); expect_dec("jal", 5'b10000, 0, 0, 1, 1, 0, 32'h800, 0, 32'h1018);
      send(32'h0000007F, 32'h101C); expect_dec("ill", 5'b00000, 0, 0, 0, 0, 0, 32'h0, 1, 32'h101C);
      send(32'h00000013, 32'h1020); check("addi_x0.rd_we", out_rd_we, 0);
      send(32'h0020A1B3, 32'h1024); check("slt.illegal", out_illegal, 1);
      tick();
      check("drain.out_valid", out_valid, 0);

      // backpressure: A held in main, B in skid, C offered but blocked
      out_ready = 0; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
      tick();
      check("bp1.in_ready", in_ready, 1);
      check("bp1.pc", out_pc, 32'h100);
      in_instr = 32'h002081B3; in_pc = 32'h104;
      tick();
      check("bp2.in_ready", in_ready, 0);
      check("bp2.pc", out_pc, 32'h100);
      in_instr = 32'h402081B3; in_pc = 32'h108;
      tick();
      check("bp3.in_ready", in_ready, 0);
      check("bp3.pc", out_pc, 32'h100);
      check("bp3.op", out_op, 5'b01100);
      in_valid = 0; out_ready = 1;
      tick();
      check("bp4.pc", out_pc, 32'h104);
      check("bp4.op", out_op, 5'b01101);
      check("bp4.in_ready", in_ready, 1);
      tick();
      check("bp5.out_valid", out_valid, 0);

      // flush with main full and a concurrent accepted input
      out_ready = 0; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h200;
      tick();
      flush = 1; in_pc = 32'h204;
      tick();
      flush = 0; in_valid = 0;
      check("fl1.out_valid", out_valid, 0);
      check("fl1.in_ready", in_ready, 1);
      tick();
      check("fl1b.out_valid", out_valid, 0);

      // flush with both entries full while fetch keeps offering
      in_valid = 1; in_pc = 32'h300;
      tick();
      in_pc = 32'h304;
      tick();
      check("fl2.pre_in_ready", in_ready, 0);
      flush = 1; in_pc = 32'h308;
      tick();
      flush = 0; in_valid = 0;
      check("fl2.out_valid", out_valid, 0);
      check("fl2.in_ready", in_ready, 1);

      // asynchronous reset mid-stream
      send(32'h002081B3, 32'h400);
      check("ar.pre_valid", out_valid, 1);
      out_ready = 0;
      #2 rst_n = 0;
      #1;
      check("ar.out_valid", out_valid, 0);
      check("ar.in_ready", in_ready, 1);
      check("ar.pc", out_pc, 0);
      rst_n = 1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
